// File: rtl/ramp_pkg.sv
// ---------------------------------------------------------------------------
// ramp_pkg -- shared definitions for the phase-shifted carrier bank.
//   PRD_DEF      : default carrier peak value
//   dir_t        : carrier count direction (DIR_UP / DIR_DN)
//   ld_state_t   : period/phase update handshake state
//   phase_map_t  : result of mapping a phase angle onto count + direction
//   map_phase()  : converts a phase angle (0..2*prd-1) into count/direction
// ---------------------------------------------------------------------------
package ramp_pkg;

  localparam int PRD_DEF = 450;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_PEND = 1'b1
  } ld_state_t;

  typedef struct packed {
    dir_t        dir;
    logic [31:0] cnt;
  } phase_map_t;

  // A triangle carrier of peak prd spends prd cycles rising and prd falling,
  // so an angle in the first half is a rising count and an angle in the
  // second half is the mirrored falling count. Angles one full period too
  // large are folded back once.
  function automatic phase_map_t map_phase(input logic [31:0] angle,
                                           input logic [31:0] prd);
    phase_map_t  m;
    logic [31:0] span;
    logic [31:0] a;
    span = prd << 1;
    a    = angle;
    if (a >= span) begin
      a = a - span;
    end
    if (a < prd) begin
      m.cnt = a;
      m.dir = DIR_UP;
    end else begin
      m.cnt = span - a;
      m.dir = DIR_DN;
    end
    return m;
  endfunction

endpackage

// File: rtl/ramp_bank_if.sv
// ---------------------------------------------------------------------------
// ramp_bank_if -- control/data bundle of the carrier bank.
//   run, ld, prd_in, phase_in            : controller -> bank
//   ld_busy, ld_err, ramp_out,
//   sync_pk, sync_vl                     : bank -> controller
// Modports: master (controller side), slave (bank side).
// ---------------------------------------------------------------------------
interface ramp_bank_if #(
  parameter int N_CH = 9,
  parameter int W    = 11
);
  logic                  run;
  logic                  ld;
  logic [W-1:0]          prd_in;
  logic [N_CH*(W+1)-1:0] phase_in;
  logic                  ld_busy;
  logic                  ld_err;
  logic [N_CH*W-1:0]     ramp_out;
  logic                  sync_pk;
  logic                  sync_vl;

  modport master (
    output run, ld, prd_in, phase_in,
    input  ld_busy, ld_err, ramp_out, sync_pk, sync_vl
  );

  modport slave (
    input  run, ld, prd_in, phase_in,
    output ld_busy, ld_err, ramp_out, sync_pk, sync_vl
  );
endinterface

// File: rtl/ramp_cell.sv
// ---------------------------------------------------------------------------
// ramp_cell -- one symmetric up/down carrier counter (0..prd..0).
//   clk, rst (async, active-low)
//   run     : advance one step per cycle when high, hold otherwise
//   ld_en   : load ld_cnt/ld_dir (takes priority over counting)
//   prd     : current peak value
//   cnt/dir : registered count and direction
// RST_CNT/RST_DIR give the reset phase of this particular channel.
// ---------------------------------------------------------------------------
module ramp_cell
  import ramp_pkg::*;
#(
  parameter int         W       = 11,
  parameter logic [W-1:0] RST_CNT = '0,
  parameter dir_t       RST_DIR = DIR_UP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         ld_en,
  input  logic [W-1:0] ld_cnt,
  input  dir_t         ld_dir,
  input  logic [W-1:0] prd,
  output logic [W-1:0] cnt,
  output dir_t         dir
);

  logic [W-1:0] cnt_reg, cnt_next;
  dir_t         dir_reg, dir_next;

  always_comb begin
    cnt_next = cnt_reg;
    dir_next = dir_reg;
    if (ld_en) begin
      cnt_next = ld_cnt;
      dir_next = ld_dir;
    end else if (run) begin
      if (dir_reg == DIR_UP) begin
        cnt_next = cnt_reg + 1'b1;
        // Turn around on the same cycle the peak is reached; >= keeps the
        // counter bounded even if it was ever left above the peak.
        if (cnt_next >= prd) begin
          dir_next = DIR_DN;
        end
      end else begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_next == '0) begin
          dir_next = DIR_UP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= RST_CNT;
      dir_reg <= RST_DIR;
    end else begin
      cnt_reg <= cnt_next;
      dir_reg <= dir_next;
    end
  end

  assign cnt = cnt_reg;
  assign dir = dir_reg;

endmodule

// File: rtl/ramp_bank.sv
// ---------------------------------------------------------------------------
// ramp_bank -- bank of N_CH phase-shifted triangle carriers sharing one peak.
//   clk          : reference clock
//   rst          : asynchronous active-low reset
//   bus (slave)  : run/ld/prd_in/phase_in in; ld_busy/ld_err/ramp_out/
//                  sync_pk/sync_vl out
// A period/phase update is captured into shadow registers on ld and applied
// to every channel at once when channel 0 sits at its valley rising (or at
// once while stopped), so all carriers change together without glitches.
// Optional build macro: RAMP_SYNC_OUT_EN builds the registered sync_pk/sync_vl
// pulses; without it the sync ports are tied low.
// ---------------------------------------------------------------------------
module ramp_bank #(
  parameter int N_CH    = 9,
  parameter int W       = 11,
  parameter int PRD_DEF = 450
) (
  input logic       clk,
  input logic       rst,
  ramp_bank_if.slave bus
);
  import ramp_pkg::*;

  localparam int PW = W + 1;

  ld_state_t             state_reg, state_next;
  logic                  ld_err_reg, ld_err_next;
  logic [W-1:0]          prd_reg;
  logic [W-1:0]          shd_prd_reg;
  logic [N_CH*PW-1:0]    shd_phase_reg;
  logic                  capture;
  logic                  apply;
  logic                  prd_ok;
  logic [W-1:0]          cnt_arr [N_CH];
  logic [N_CH-1:0]       dir_vec;
  dir_t                  dir0;
  logic [N_CH*W-1:0]     ramp_flat;
  logic [N_CH-1:0]       cnt_hi_vec;
  logic                  map_hi_unused;

  assign prd_ok = (bus.prd_in >= W'(2));
  assign dir0   = dir_t'(dir_vec[0]);

  // Update handshake: IDLE accepts a valid ld, PEND waits for the apply point.
  always_comb begin
    state_next  = state_reg;
    ld_err_next = ld_err_reg;
    capture     = 1'b0;
    apply       = 1'b0;
    case (state_reg)
      LD_IDLE: begin
        if (bus.ld) begin
          if (prd_ok) begin
            capture     = 1'b1;
            ld_err_next = 1'b0;
            state_next  = LD_PEND;
          end else begin
            ld_err_next = 1'b1;
          end
        end
      end
      LD_PEND: begin
        if (bus.ld) begin
          ld_err_next = 1'b1;
        end
        if (!bus.run || (cnt_arr[0] == '0 && dir0 == DIR_UP)) begin
          apply      = 1'b1;
          state_next = LD_IDLE;
        end
      end
      default: state_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= LD_IDLE;
      ld_err_reg    <= 1'b0;
      prd_reg       <= W'(PRD_DEF);
      shd_prd_reg   <= W'(PRD_DEF);
      shd_phase_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ld_err_reg <= ld_err_next;
      if (capture) begin
        shd_prd_reg   <= bus.prd_in;
        shd_phase_reg <= bus.phase_in;
      end
      if (apply) begin
        prd_reg <= shd_prd_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      // Reset phase: channels spread evenly over one full carrier period.
      localparam logic [31:0] RST_ANGLE = 32'((gi * 2 * PRD_DEF) / N_CH);
      localparam phase_map_t  RST_MAP   = map_phase(RST_ANGLE, 32'(PRD_DEF));

      phase_map_t ld_map;
      logic       cell_dir;
      dir_t       cell_dir_t;

      assign ld_map = map_phase(32'(shd_phase_reg[gi*PW +: PW]), 32'(shd_prd_reg));

      ramp_cell #(
        .W       (W),
        .RST_CNT (W'(RST_MAP.cnt)),
        .RST_DIR (RST_MAP.dir)
      ) u_cell (
        .clk    (clk),
        .rst    (rst),
        .run    (bus.run),
        .ld_en  (apply),
        .ld_cnt (W'(ld_map.cnt)),
        .ld_dir (ld_map.dir),
        .prd    (prd_reg),
        .cnt    (cnt_arr[gi]),
        .dir    (cell_dir_t)
      );

      assign cell_dir              = cell_dir_t;
      assign dir_vec[gi]           = cell_dir;
      assign ramp_flat[gi*W +: W]  = cnt_arr[gi];
      // Mapped counts never exceed the W-bit peak; the upper bits are zero.
      assign cnt_hi_vec[gi]        = |ld_map.cnt[31:W];
    end
  endgenerate

  // Only channel 0's direction steers the apply point; the others and the
  // always-zero high bits of the mapping result are intentionally dropped.
  assign map_hi_unused = ^{cnt_hi_vec, dir_vec};

  assign bus.ramp_out = ramp_flat;
  assign bus.ld_busy  = (state_reg == LD_PEND);
  assign bus.ld_err   = ld_err_reg;

`ifdef RAMP_SYNC_OUT_EN
  logic sync_pk_reg;
  logic sync_vl_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_pk_reg <= 1'b0;
      sync_vl_reg <= 1'b0;
    end else begin
      sync_pk_reg <= bus.run && (cnt_arr[0] == prd_reg);
      sync_vl_reg <= bus.run && (cnt_arr[0] == '0);
    end
  end

  assign bus.sync_pk = sync_pk_reg;
  assign bus.sync_vl = sync_vl_reg;
`else
  assign bus.sync_pk = 1'b0;
  assign bus.sync_vl = 1'b0;
`endif

endmodule

// File: doc/ramp_bank.md
RAMP_BANK -- requirements
Module: ramp_bank

Interface
REQ-001 Parameter N_CH, default 9, number of phase-shifted carrier channels (1..16).
REQ-002 Parameter W, default 11, carrier counter width in bits.
REQ-003 Parameter PRD_DEF, default 450, carrier peak value loaded at reset.
REQ-004 clk  input  1  reference clock; all state updates on posedge.
REQ-005 rst  input  1  master reset; asynchronous, active-low.
REQ-006 run  input  1  1 = carriers advance each cycle; 0 = carriers hold value and direction.
REQ-007 ld  input  1  one-cycle strobe requesting a period/phase update.
REQ-008 prd_in  input  W  new peak value, sampled on ld.
REQ-009 phase_in  input  N_CH*(W+1)  per-channel phase angle, channel i in bits [i*(W+1) +: W+1], range 0..2*prd-1, sampled on ld.
REQ-010 ld_busy  output  1  high from ld acceptance until the update is applied.
REQ-011 ld_err  output  1  sticky; set when a rejected ld occurs, cleared by the next accepted ld.
REQ-012 ramp_out  output  N_CH*W  per-channel carrier value, channel i in bits [i*W +: W].
REQ-013 sync_pk  output  1  one-cycle pulse when channel 0 reaches its peak.
REQ-014 sync_vl  output  1  one-cycle pulse when channel 0 reaches zero.

Function
REQ-015 Each channel is a symmetric up/down counter between 0 and prd, with a period of 2*prd cycles while run=1.
REQ-016 Counting up: +1 per cycle; on the cycle the count becomes prd, direction flips to down.
REQ-017 Counting down: -1 per cycle; on the cycle the count becomes 0, direction flips to up.
REQ-018 Phase mapping: angle a < prd loads count=a, dir=up; a >= prd loads count=2*prd-a, dir=down.
REQ-019 Phase angles >= 2*prd are reduced by 2*prd once before mapping.
REQ-020 ld while ld_busy=0 and 2 <= prd_in <= 2^W-1: capture prd_in and phase_in into shadow registers, and assert ld_busy on the next cycle.
REQ-021 ld with prd_in < 2: rejected; shadows are unchanged and ld_err=1.
REQ-022 ld while ld_busy=1: ignored; ld_err=1.
REQ-023 Apply point: the first cycle on which channel 0 count is 0 with dir=up, or immediately if run=0.
REQ-024 At the apply point, all channels reload from the shadows per REQ-018, prd updates, and ld_busy drops on the same edge.
REQ-025 sync_pk/sync_vl are registered and fire in the cycle after channel 0 output equals prd/0; neither fires while run=0.
REQ-026 ramp_out is driven directly from the counter registers, with zero combinational latency.

Reset
REQ-027 rst=0 asynchronously sets prd=PRD_DEF, channel i phase angle = (i*2*PRD_DEF)/N_CH mapped per REQ-018, and ld_busy=ld_err=sync_pk=sync_vl=0.
REQ-028 Reset mid-update discards the pending shadow contents.

Configuration
REQ-029 With RAMP_SYNC_OUT_EN defined, sync_pk/sync_vl behave per REQ-025.
REQ-030 Without RAMP_SYNC_OUT_EN, the sync ports remain present but are tied to 0 and their registers are not built.

Structure
REQ-031 Shared package ramp_pkg holds PRD_DEF, the direction enum (DIR_UP/DIR_DN), and the phase-mapping function.
REQ-032 The per-channel counter is the sub-module ramp_cell (count, dir, load port), instantiated N_CH times via generate.

Verification
REQ-033 Reset release, N_CH=9, PRD_DEF=450, run=1 -> channel i starts at i*100 (i>=5: 900-i*100, dir down); each channel has a period of 900 cycles.
REQ-034 Channel 0 from 0 -> reaches 450 after 450 cycles, sync_pk fires one cycle later, and sync_vl fires 450 cycles after that.
REQ-035 ld with prd_in=300 and all phases 0, mid-ramp -> ld_busy high until channel 0 valley, then all channels equal 0 and the peak is 300.
REQ-036 ld with prd_in=1 -> ld_err=1, no change; a following valid ld clears ld_err.
REQ-037 run=0 for 20 cycles at count 123 down -> holds 123; resuming gives 122.
REQ-038 rst asserted while ld_busy=1 -> immediate return to the REQ-027 state; the pending update is never applied.
